// File: rtl/bus_grant_scheduler.sv
// Round-robin owner selection for the shared 16-slot register/memory bus.
// Defining GRANT_TIMEOUT_EN adds a hold counter that force-revokes grants after MAX_HOLD cycles.
module bus_grant_scheduler #(
   parameter int N_REQ    = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             grant_release,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N_REQ-1:0] grant_onehot,
   output logic             busy,
   output logic             timeout,
   output logic [1:0]       state_dbg
);

   // Handshake: req[i] is a level held until requester i owns the bus; grant_release is a
   // one-cycle pulse from the owner that is honoured only in GRANT and ignored elsewhere.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] scan_idx;
   logic [IDX_W-1:0] cand;
   logic             scan_found;
   logic             hold_expired;
   logic             exit_grant;

   // Scan starts at ptr; the IDX_W-bit add wraps 15 -> 0 by itself.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = '0;
      cand       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!scan_found && req[cand]) begin
            scan_found = 1'b1;
            scan_idx   = cand;
         end
      end
   end

`ifdef GRANT_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       timeout_r;

   assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));

   // A release or an abandoned request wins over a coincident expiry, so no pulse then.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= 1'b0;
         if (state == ST_IDLE) begin
            hold_cnt <= '0;
         end else if (state == ST_GRANT) begin
            if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
            if (hold_expired && !grant_release && req[grant_idx]) timeout_r <= 1'b1;
         end
      end
   end

   assign timeout = timeout_r;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   assign exit_grant = grant_release || !req[grant_idx] || hold_expired;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (scan_found) begin
                  state       <= ST_GRANT;
                  grant_valid <= 1'b1;
                  grant_idx   <= scan_idx;
                  busy        <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (exit_grant) begin
                  state       <= ST_GAP;
                  grant_valid <= 1'b0;
                  grant_idx   <= '0;
                  ptr         <= grant_idx + IDX_W'(1);
               end
            end
            ST_GAP: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               grant_valid <= 1'b0;
               grant_idx   <= '0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

   assign grant_onehot = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
   assign state_dbg    = state;

endmodule
